// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// The default configuration is the classic overlapping "010" detector.
package seq_det_pkg;

    // Bits needed to hold any length 0..max_len inclusive.
    function automatic int clog2_len(input int max_len);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < (max_len + 1)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int         DEF_MAX_LEN   = 8;
    localparam int         DEF_CNT_W     = 16;
    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_0010;
    localparam int         DEF_LEN_C     = 3;
    localparam bit         DEF_OVERLAP_C = 1'b1;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } ovl_mode_e;

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable Moore serial pattern detector with overlap control,
// input qualification and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int                LEN_W       = clog2_len(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    // A bit on x is taken on every rising edge with in_valid=1 and cfg_load=0;
    // there is no back-pressure, the detector always accepts.
    input  logic               in_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] pattern_q;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_nxt;
    logic [LEN_W-1:0]   fill_inc;
    ovl_mode_e          ovl_q;
    logic               match_q;
    logic               match_nxt;
    logic               err_q;
    logic               err_nxt;
    logic               hit;
    logic               cfg_ok;

    assign cfg_ok = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);

    // Only the low cur_len bits of history and pattern take part in a compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign hist_shift = {hist_q[MAX_LEN-2:0], x};
    assign fill_inc   = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
    assign hit        = (fill_inc == len_q) &&
                        ((hist_shift & len_mask) == (pattern_q & len_mask));

    always_comb begin
        hist_nxt  = hist_q;
        fill_nxt  = fill_q;
        match_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (cfg_load) begin
            hist_nxt = '0;
            fill_nxt = '0;
            err_nxt  = !cfg_ok;
        end else if (in_valid) begin
            hist_nxt  = hist_shift;
            match_nxt = hit;
            // In non-overlap mode the matched bits are consumed.
            fill_nxt  = (hit && (ovl_q == NON_OVERLAP)) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            hist_q  <= hist_nxt;
            fill_q  <= fill_nxt;
            match_q <= match_nxt;
            err_q   <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= ovl_mode_e'(DEF_OVERLAP);
        end else if (cfg_load && cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            ovl_q     <= ovl_mode_e'(cfg_overlap);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (match_nxt),
        .q       (match_count)
    );

    assign match   = match_q;
    assign fill    = fill_q;
    assign cfg_err = err_q;

endmodule
